// File: rtl/mem_mapper_if.sv
// mem_mapper_if: CPU/VPU/SRAM bus bundle between the system and mem_mapper.
// Signals:
//   AD, DI, rw, vma, cs, ext_sel   CPU cycle and decode qualifiers
//   DO                             register read data
//   vramreq, VADDR, vramack        VPU fetch handshake
//   EXT_AD                         physical SRAM address (PA bits)
//   hold, bram_disable             CPU stall and BRAM unmap
//   irq                            write-protect fault (MAPPER_FAULT_IRQ_EN builds only)
// Modports: master drives the CPU/VPU side, slave is the mapper.
interface mem_mapper_if #(parameter int PA = 17);
    logic [15:0]   AD;
    logic [7:0]    DI;
    logic [7:0]    DO;
    logic          rw;
    logic          vma;
    logic          cs;
    logic          ext_sel;
    logic          vramreq;
    logic [15:0]   VADDR;
    logic          vramack;
    logic [PA-1:0] EXT_AD;
    logic          hold;
    logic          bram_disable;
`ifdef MAPPER_FAULT_IRQ_EN
    logic          irq;
    modport master (output AD, DI, rw, vma, cs, ext_sel, vramreq, VADDR,
                    input DO, vramack, EXT_AD, hold, bram_disable, irq);
    modport slave (input AD, DI, rw, vma, cs, ext_sel, vramreq, VADDR,
                   output DO, vramack, EXT_AD, hold, bram_disable, irq);
`else
    modport master (output AD, DI, rw, vma, cs, ext_sel, vramreq, VADDR,
                    input DO, vramack, EXT_AD, hold, bram_disable);
    modport slave (input AD, DI, rw, vma, cs, ext_sel, vramreq, VADDR,
                   output DO, vramack, EXT_AD, hold, bram_disable);
`endif
endinterface

// File: rtl/mem_mapper.sv
// mem_mapper: paged 8 KB window mapper, wait-state generator and video/CPU arbiter.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   mem_mapper_if.slave (CPU cycle, register file, VPU handshake, SRAM address, hold)
// Optional build macro MAPPER_FAULT_IRQ_EN adds sticky write-protect fault status
// in register 6 and drives bus.irq from it.
module mem_mapper #(
    parameter int WINDOWS    = 2,
    parameter int BASE_SLOT  = 6,
    parameter int PAGE_BITS  = 4,
    parameter int WS_DEFAULT = 1
) (
    input logic         clk,
    input logic         rst,
    mem_mapper_if.slave bus
);
    localparam int PA = PAGE_BITS + 13;
    localparam logic [3:0] WMASK = 4'((1 << WINDOWS) - 1);
    typedef enum logic [1:0] {IDLE, WAIT, DONE, VIDEO} state_t;
    logic [PAGE_BITS-1:0] page [WINDOWS];
    logic [3:0] en, wp;
    logic [2:0] ws, cnt;
    logic bd, hold_r, ack_r, hit;
    logic [PAGE_BITS-2:0] hit_page;
    logic [7:0] rd_data;
    state_t state;
    wire reg_wr = bus.cs && bus.vma && !bus.rw;
`ifdef MAPPER_FAULT_IRQ_EN
    logic wp_fault, fault;
    logic [1:0] fault_idx, fidx;
`endif
    // A write into a protected window is not mapped, so it lands on whatever
    // sits underneath in the flat address space (shadow RAM under ROM).
    always_comb begin
        hit = 1'b0;
        hit_page = '0;
`ifdef MAPPER_FAULT_IRQ_EN
        wp_fault = 1'b0;
        fault_idx = '0;
`endif
        for (int k = 0; k < WINDOWS; k++)
            if (bus.vma && en[k] && bus.AD[15:13] == 3'(BASE_SLOT + k)) begin
                if (bus.rw || !wp[k]) begin
                    hit = 1'b1;
                    hit_page = page[k][PAGE_BITS-2:0];
                end
`ifdef MAPPER_FAULT_IRQ_EN
                else begin
                    wp_fault = 1'b1;
                    fault_idx = 2'(k);
                end
`endif
            end
    end
    // Mapped addresses sit in the upper half of SRAM (MSB forced to 1).
    assign bus.EXT_AD = state == VIDEO ? PA'(bus.VADDR)
                      : hit ? {1'b1, hit_page, bus.AD[12:0]} : PA'(bus.AD);
    always_comb begin
        rd_data = 8'hFF;
        for (int k = 0; k < WINDOWS; k++)
            if (bus.AD[2:0] == 3'(k)) rd_data = 8'(page[k]);
        if (bus.AD[2:0] == 3'd4) rd_data = {wp, en};
        if (bus.AD[2:0] == 3'd5) rd_data = {4'b0, ws, bd};
`ifdef MAPPER_FAULT_IRQ_EN
        if (bus.AD[2:0] == 3'd6) rd_data = {5'b0, fidx, fault};
`endif
    end
    assign bus.DO = rd_data;
    assign bus.hold = hold_r;
    assign bus.vramack = ack_r;
    assign bus.bram_disable = bd;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < WINDOWS; k++) page[k] <= '0;
            en <= '0;
            wp <= '0;
            ws <= 3'(WS_DEFAULT);
            bd <= 1'b0;
        end else if (reg_wr) begin
            for (int k = 0; k < WINDOWS; k++)
                if (bus.AD[2:0] == 3'(k)) page[k] <= bus.DI[PAGE_BITS-1:0];
            if (bus.AD[2:0] == 3'd4) begin
                en <= bus.DI[3:0] & WMASK;
                wp <= bus.DI[7:4] & WMASK;
            end
            if (bus.AD[2:0] == 3'd5) begin
                bd <= bus.DI[0];
                ws <= bus.DI[3:1];
            end
        end
    end
`ifdef MAPPER_FAULT_IRQ_EN
    // A new fault takes priority over a software clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault <= 1'b0;
            fidx <= '0;
        end else if (wp_fault) begin
            fault <= 1'b1;
            fidx <= fault_idx;
        end else if (reg_wr && bus.AD[2:0] == 3'd6 && bus.DI[0]) fault <= 1'b0;
    end
    assign bus.irq = fault;
`endif
    // hold/vramack are registered from the next-state decision; vramack is
    // raised on the cycle the video counter reaches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            hold_r <= 1'b0;
            ack_r <= 1'b0;
        end else case (state)
            IDLE:
                if (bus.vramreq) begin
                    state <= VIDEO;
                    cnt <= ws;
                    hold_r <= 1'b1;
                    ack_r <= ws == 3'd0;
                end else if (bus.ext_sel && bus.vma && ws != 3'd0) begin
                    state <= WAIT;
                    cnt <= ws - 3'd1;
                    hold_r <= 1'b1;
                end
            WAIT:
                if (cnt == 3'd0) begin
                    state <= DONE;
                    hold_r <= 1'b0;
                end else cnt <= cnt - 3'd1;
            DONE: state <= IDLE;
            VIDEO:
                if (cnt == 3'd0) begin
                    state <= IDLE;
                    hold_r <= 1'b0;
                    ack_r <= 1'b0;
                end else begin
                    cnt <= cnt - 3'd1;
                    ack_r <= cnt == 3'd1;
                end
            default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_mapper.sv
// tb_mem_mapper: directed plus randomized checks of mem_mapper against a spec-level model.
module tb_mem_mapper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int pg [2];
    logic [7:0] ctrl_m;
    logic [2:0] ws_m;
    logic bd_m;
    logic fault_m;
    always #5 clk = ~clk;
    mem_mapper_if #(.PA(17)) bus();
    mem_mapper #(.WINDOWS(2), .BASE_SLOT(6), .PAGE_BITS(4), .WS_DEFAULT(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask
    function automatic logic [16:0] exp_ad(input logic [15:0] a, input logic r, input logic v);
        int ai = int'(a);
        for (int k = 0; k < 2; k++)
            if (v && ctrl_m[k] && ai / 8192 == 6 + k && !(!r && ctrl_m[4+k]))
                return 17'(65536 + (pg[k] % 8) * 8192 + ai % 8192);
        return {1'b0, a};
    endfunction
    function automatic logic [7:0] rd_exp(input int a);
        if (a < 2) return 8'(pg[a]);
        if (a == 4) return ctrl_m;
        if (a == 5) return {4'b0, ws_m, bd_m};
`ifdef MAPPER_FAULT_IRQ_EN
        if (a == 6) return {7'b0, fault_m};
`endif
        return 8'hFF;
    endfunction
    task automatic model_reset();
        pg[0] = 0;
        pg[1] = 0;
        ctrl_m = 8'h00;
        ws_m = 3'd1;
        bd_m = 1'b0;
        fault_m = 1'b0;
    endtask
    task automatic wr(input int a, input logic [7:0] d);
        bus.cs = 1'b1;
        bus.vma = 1'b1;
        bus.rw = 1'b0;
        bus.AD = 16'(a);
        bus.DI = d;
        @(posedge clk);
        #1;
        bus.cs = 1'b0;
        bus.vma = 1'b0;
        bus.rw = 1'b1;
        if (a < 2) pg[a] = int'(d) % 16;
        if (a == 4) ctrl_m = d & 8'h33;
        if (a == 5) begin
            bd_m = d[0];
            ws_m = d[3:1];
        end
        if (a == 6 && d[0]) fault_m = 1'b0;
    endtask
    task automatic rd_chk(input string tag, input int a, input logic [7:0] exp_v);
        bus.cs = 1'b1;
        bus.vma = 1'b1;
        bus.rw = 1'b1;
        bus.AD = 16'(a);
        #1;
        chk(tag, 32'(bus.DO), 32'(exp_v));
        bus.cs = 1'b0;
        bus.vma = 1'b0;
        @(posedge clk);
        #1;
    endtask
    task automatic probe(input string tag, input logic [15:0] a, input logic r, input logic v,
                         input logic [16:0] exp_v);
        bus.AD = a;
        bus.rw = r;
        bus.vma = v;
        #1;
        chk(tag, 32'(bus.EXT_AD), 32'(exp_v));
        bus.vma = 1'b0;
        bus.rw = 1'b1;
        @(posedge clk);
        #1;
    endtask
    // Issues one external CPU access and returns how many cycles hold was high.
    task automatic ext_access(output int n);
        bus.ext_sel = 1'b1;
        bus.vma = 1'b1;
        bus.rw = 1'b1;
        bus.AD = 16'h8000;
        @(posedge clk);
        #1;
        n = 0;
        while (bus.hold && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("done_hold", 32'(bus.hold), 0);
        @(posedge clk);
        #1;
        bus.ext_sel = 1'b0;
        bus.vma = 1'b0;
        chk("no_retrigger", 32'(bus.hold), 0);
    endtask
    // Video fetch colliding with a CPU external access; checks ordering and lengths.
    task automatic video_collision(input logic [15:0] va);
        int n, ack_at, m;
        bus.VADDR = va;
        bus.vramreq = 1'b1;
        bus.ext_sel = 1'b1;
        bus.vma = 1'b1;
        bus.rw = 1'b1;
        bus.AD = 16'h8123;
        @(posedge clk);
        #1;
        chk("video_ext_ad", 32'(bus.EXT_AD), 32'(va));
        n = 0;
        ack_at = 0;
        while (bus.hold && n < 20) begin
            n++;
            if (bus.vramack) begin
                if (ack_at == 0) ack_at = n;
                bus.vramreq = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk("video_hold_len", 32'(n), 32'(int'(ws_m) + 1));
        chk("video_ack_cycle", 32'(ack_at), 32'(int'(ws_m) + 1));
        chk("video_ack_pulse", 32'(bus.vramack), 0);
        @(posedge clk);
        #1;
        m = 0;
        while (bus.hold && m < 20) begin
            m++;
            @(posedge clk);
            #1;
        end
        chk("cpu_after_video", 32'(m), 32'(ws_m));
        @(posedge clk);
        #1;
        bus.ext_sel = 1'b0;
        bus.vma = 1'b0;
    endtask
    initial begin
        int n;
        logic [2:0] w;
        bus.AD = '0;
        bus.DI = '0;
        bus.rw = 1'b1;
        bus.vma = 1'b0;
        bus.cs = 1'b0;
        bus.ext_sel = 1'b0;
        bus.vramreq = 1'b0;
        bus.VADDR = '0;
        model_reset();
        #12;
        chk("rst_hold", 32'(bus.hold), 0);
        chk("rst_vramack", 32'(bus.vramack), 0);
        chk("rst_bram_disable", 32'(bus.bram_disable), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd_chk("rst_reg0", 0, 8'h00);
        rd_chk("rst_reg4", 4, 8'h00);
        rd_chk("rst_reg5", 5, 8'h02);
        for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_reg%0d_model", a), a, rd_exp(a));
        probe("rst_flat", 16'hC123, 1'b1, 1'b1, 17'h0C123);
        wr(0, 8'h05);
        wr(4, 8'h01);
        probe("win0_read", 16'hC123, 1'b1, 1'b1, 17'h1A123);
        probe("outside_win", 16'hE123, 1'b1, 1'b1, 17'h0E123);
        probe("win0_no_vma", 16'hC123, 1'b1, 1'b0, 17'h0C123);
        wr(4, 8'hFF);
        rd_chk("ctrl_mask", 4, 8'h33);
        wr(4, 8'h11);
        probe("wp_write_falls", 16'hC010, 1'b0, 1'b1, 17'h0C010);
`ifdef MAPPER_FAULT_IRQ_EN
        chk("irq_idle", 32'(bus.irq), 0);
        bus.AD = 16'hC010;
        bus.rw = 1'b0;
        bus.vma = 1'b1;
        @(posedge clk);
        #1;
        bus.vma = 1'b0;
        bus.rw = 1'b1;
        fault_m = 1'b1;
        chk("irq_set", 32'(bus.irq), 1);
        rd_chk("fault_reg", 6, 8'h01);
        wr(6, 8'h01);
        chk("irq_clear", 32'(bus.irq), 0);
`else
        rd_chk("reg6_absent", 6, 8'hFF);
`endif
        probe("wp_read_maps", 16'hC010, 1'b1, 1'b1, 17'h1A010);
        wr(1, 8'hFB);
        rd_chk("page1_width", 1, 8'h0B);
        probe("win1_disabled", 16'hE123, 1'b1, 1'b1, 17'h0E123);
        wr(4, 8'h03);
        probe("win1_read", 16'hE123, 1'b1, 1'b1, 17'h16123);
        wr(5, 8'h06);
        ext_access(n);
        chk("ws3_hold", 32'(n), 3);
        wr(5, 8'h00);
        ext_access(n);
        chk("ws0_hold", 32'(n), 0);
        for (int i = 0; i < 4; i++) begin
            w = 3'($urandom_range(0, 7));
            wr(5, {4'($urandom), w, 1'($urandom)});
            chk("bram_disable", 32'(bus.bram_disable), 32'(bd_m));
            ext_access(n);
            chk($sformatf("ws%0d_hold", ws_m), 32'(n), 32'(ws_m));
        end
        wr(5, 8'h02);
        video_collision(16'h3ABC);
        for (int i = 0; i < 3; i++) begin
            wr(5, {4'b0, 3'($urandom_range(0, 7)), 1'b0});
            video_collision(16'($urandom));
        end
        for (int i = 0; i < 12; i++) begin
            int a = $urandom_range(0, 7);
            wr(a, 8'($urandom));
            rd_chk($sformatf("rand_reg%0d", a), a, rd_exp(a));
            for (int j = 0; j < 3; j++) begin
                logic [15:0] ad = {3'($urandom_range(5, 7)), 13'($urandom)};
                logic r = 1'($urandom);
                logic v = 1'($urandom_range(0, 3) != 0);
                probe("rand_ext_ad", ad, r, v, exp_ad(ad, r, v));
            end
        end
        wr(0, 8'h09);
        wr(4, 8'h03);
        wr(5, 8'h06);
        bus.ext_sel = 1'b1;
        bus.vma = 1'b1;
        bus.rw = 1'b1;
        bus.AD = 16'h8000;
        @(posedge clk);
        #1;
        chk("wait_hold", 32'(bus.hold), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_hold", 32'(bus.hold), 0);
        chk("async_rst_vramack", 32'(bus.vramack), 0);
        bus.ext_sel = 1'b0;
        bus.vma = 1'b0;
        model_reset();
        rd_chk("rst2_reg0", 0, 8'h00);
        rd_chk("rst2_reg4", 4, 8'h00);
        rd_chk("rst2_reg5", 5, 8'h02);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst2_idle_hold", 32'(bus.hold), 0);
        ext_access(n);
        chk("rst2_default_ws", 32'(n), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
